// File: rtl/ps2_paddle_keys.sv
// ps2_paddle_keys
// PS/2 keyboard receiver plus Set-2 scancode decoder that keeps one held bit
// per paddle key. The raw PS/2 lines are synchronized and the clock is glitch
// filtered before a small receive FSM assembles 11-bit frames. A decoder then
// tracks the E0/F0 prefixes and sets or clears the mapped key bits.

`timescale 1ns/1ps

module ps2_paddle_keys #(
    parameter int          FILTER_LEN = 8,
    parameter int          TIMEOUT    = 200000,
    parameter logic [7:0]  KEY_LU     = 8'h1D,
    parameter logic [7:0]  KEY_LD     = 8'h1B,
    parameter logic [7:0]  KEY_RU     = 8'h75,
    parameter logic [7:0]  KEY_RD     = 8'h72
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] key_out,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err
);

    // Counter widths sized so the terminal values always fit.
    localparam int FILT_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    typedef enum logic {
        IDLE,
        RECV
    } rxState_t;

    // Synchronizer stages. Idle PS/2 lines are high, so reset to 1.
    logic              r_clkMeta;
    logic              r_clkSync;
    logic              r_dataMeta;
    logic              r_dataSync;

    // Glitch filter state and the falling-edge strobe with its data sample.
    logic              r_clkFilt;
    logic [FILT_W-1:0] r_filtCnt;
    logic              r_fallStb;
    logic              r_dataBit;

    // Receive FSM state.
    rxState_t          r_state;
    logic [3:0]        r_bitCnt;
    logic [7:0]        r_shift;
    logic              r_parity;
    logic [TO_W-1:0]   r_timeout;
    logic [7:0]        r_code;
    logic              r_codeValid;
    logic              r_frameErr;

    // Decoder state.
    logic              r_ext;
    logic              r_brk;
    logic [3:0]        r_keys;

    // Frame quality: odd parity over data plus parity bit.
    logic              w_parityOk;
    logic              w_filtDone;

    assign w_parityOk = (^r_shift) ^ r_parity;
    assign w_filtDone = (r_filtCnt == FILT_W'(FILTER_LEN - 1));

    // Two-flop synchronizers for the asynchronous PS/2 clock and data lines.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clkMeta  <= 1'b1;
            r_clkSync  <= 1'b1;
            r_dataMeta <= 1'b1;
            r_dataSync <= 1'b1;
        end else begin
            r_clkMeta  <= ps2_clk;
            r_clkSync  <= r_clkMeta;
            r_dataMeta <= ps2_data;
            r_dataSync <= r_dataMeta;
        end
    end

    // Accept a new PS/2 clock level only after FILTER_LEN consecutive equal
    // samples; a filtered 1->0 change strobes a falling edge and latches data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clkFilt <= 1'b1;
            r_filtCnt <= '0;
            r_fallStb <= 1'b0;
            r_dataBit <= 1'b1;
        end else begin
            r_fallStb <= 1'b0;
            if (r_clkSync == r_clkFilt) begin
                r_filtCnt <= '0;
            end else if (w_filtDone) begin
                r_filtCnt <= '0;
                r_clkFilt <= r_clkSync;
                if (!r_clkSync) begin
                    r_fallStb <= 1'b1;
                    r_dataBit <= r_dataSync;
                end
            end else begin
                r_filtCnt <= r_filtCnt + FILT_W'(1);
            end
        end
    end

    // Receive FSM: start bit, 8 data bits LSB first, parity, stop; aborts a
    // partial frame when no falling edge arrives for TIMEOUT cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_bitCnt    <= '0;
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_timeout   <= '0;
            r_code      <= '0;
            r_codeValid <= 1'b0;
            r_frameErr  <= 1'b0;
        end else begin
            r_codeValid <= 1'b0;
            r_frameErr  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_timeout <= '0;
                    if (r_fallStb && !r_dataBit) begin
                        r_state  <= RECV;
                        r_bitCnt <= '0;
                    end
                end
                RECV: begin
                    if (r_fallStb) begin
                        r_timeout <= '0;
                        r_bitCnt  <= r_bitCnt + 4'd1;
                        if (r_bitCnt < 4'd8) begin
                            r_shift <= {r_dataBit, r_shift[7:1]};
                        end else if (r_bitCnt == 4'd8) begin
                            r_parity <= r_dataBit;
                        end else begin
                            r_state  <= IDLE;
                            r_bitCnt <= '0;
                            if (w_parityOk && r_dataBit) begin
                                r_code      <= r_shift;
                                r_codeValid <= 1'b1;
                            end else begin
                                r_frameErr <= 1'b1;
                            end
                        end
                    end else if (r_timeout == TO_W'(TIMEOUT)) begin
                        r_frameErr <= 1'b1;
                        r_state    <= IDLE;
                        r_bitCnt   <= '0;
                        r_timeout  <= '0;
                    end else begin
                        r_timeout <= r_timeout + TO_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Scancode decoder: E0/F0 arm the prefixes, any other byte applies them
    // to the mapped keys and then clears them; receive errors drop prefixes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_keys <= '0;
            r_ext  <= 1'b0;
            r_brk  <= 1'b0;
        end else if (r_frameErr) begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
        end else if (r_codeValid) begin
            if (r_code == CODE_EXT) begin
                r_ext <= 1'b1;
            end else if (r_code == CODE_BRK) begin
                r_brk <= 1'b1;
            end else begin
                if (!r_ext && (r_code == KEY_LU)) begin
                    r_keys[3] <= !r_brk;
                end
                if (!r_ext && (r_code == KEY_LD)) begin
                    r_keys[2] <= !r_brk;
                end
                if (r_ext && (r_code == KEY_RU)) begin
                    r_keys[1] <= !r_brk;
                end
                if (r_ext && (r_code == KEY_RD)) begin
                    r_keys[0] <= !r_brk;
                end
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end
        end
    end

    assign key_out    = r_keys;
    assign code       = r_code;
    assign code_valid = r_codeValid;
    assign frame_err  = r_frameErr;

endmodule
